// File: rtl/guard_pkg.sv
// Shared guard types and screen geometry, used by the patrol controller and the motion block.
package guard_pkg;

  typedef enum logic [2:0] {
    LEFT  = 3'b000,
    RIGHT = 3'b001,
    DOWN  = 3'b010,
    UP    = 3'b011,
    NONE  = 3'b100
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WALK    = 2'd1,
    BLOCKED = 2'd2
  } motion_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 17;
  localparam int SPRITE_H = 17;
  localparam int POS_W    = 10;

  // Codes 100..111 all mean "stand still".
  function automatic logic dir_valid(input logic [2:0] d);
    return ~d[2];
  endfunction

endpackage

// File: rtl/guard_anim_ctr.sv
// Walk-cycle animation counter: a tick divider feeding a wrapping 2-bit frame index.
module guard_anim_ctr #(
  parameter int ANIM_DIV = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [1:0] anim_frame_o
);

  localparam int            DW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    frame_q, frame_d;

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (clear_i) begin
      div_d   = '0;
      frame_d = 2'd0;
    end else if (advance_i) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        frame_d = frame_q + 2'd1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= '0;
      frame_q <= 2'd0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  assign anim_frame_o = frame_q;

endmodule

// File: rtl/guard_motion.sv
// Guard motion: turns the per-frame direction code into a clamped screen position,
// facing and walk state, and drives the walk animation counter.
module guard_motion
  import guard_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = SCREEN_W - SPRITE_W,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = SCREEN_H - SPRITE_H,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 240,
  parameter int STEP     = 1,
  parameter int ANIM_DIV = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_tick,
  input  logic [2:0]       direction_guard,
  output logic [POS_W-1:0] guard_x,
  output logic [POS_W-1:0] guard_y,
  output logic [1:0]       guard_facing,
  output logic [1:0]       anim_frame,
  output logic             moving,
  output logic             blocked
);

  // One extra bit so the bound compares never wrap.
  localparam logic [POS_W:0] STEP_E = (POS_W+1)'(STEP);
  localparam logic [POS_W:0] XLO_E  = (POS_W+1)'(X_MIN);
  localparam logic [POS_W:0] XHI_E  = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0] YLO_E  = (POS_W+1)'(Y_MIN);
  localparam logic [POS_W:0] YHI_E  = (POS_W+1)'(Y_MAX);

  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [POS_W:0]   x_e, y_e;
  logic [1:0]       facing_q;
  motion_state_t    state_q, state_d;
  logic             d_ok;

  assign d_ok = dir_valid(direction_guard);
  assign x_e  = {1'b0, x_q};
  assign y_e  = {1'b0, y_q};

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    case (direction_guard)
      LEFT:  x_d = (x_e < XLO_E + STEP_E) ? POS_W'(X_MIN) : POS_W'(x_e - STEP_E);
      RIGHT: x_d = (x_e > XHI_E - STEP_E) ? POS_W'(X_MAX) : POS_W'(x_e + STEP_E);
      UP:    y_d = (y_e < YLO_E + STEP_E) ? POS_W'(Y_MIN) : POS_W'(y_e - STEP_E);
      DOWN:  y_d = (y_e > YHI_E - STEP_E) ? POS_W'(Y_MAX) : POS_W'(y_e + STEP_E);
      default: ;
    endcase
    if (!d_ok)
      state_d = IDLE;
    else if (x_d != x_q || y_d != y_q)
      state_d = WALK;
    else
      state_d = BLOCKED;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      x_q      <= POS_W'(X_INIT);
      y_q      <= POS_W'(Y_INIT);
      facing_q <= 2'b01;
    end else if (frame_tick) begin
      state_q <= state_d;
      if (d_ok) begin
        facing_q <= direction_guard[1:0];
        x_q      <= x_d;
        y_q      <= y_d;
      end
    end
  end

  // Divider runs only on ticks that land in WALK; any other tick resets the cycle.
  guard_anim_ctr #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .clear_i      (frame_tick && (state_d != WALK)),
    .advance_i    (frame_tick && (state_d == WALK)),
    .anim_frame_o (anim_frame)
  );

  assign guard_x      = x_q;
  assign guard_y      = y_q;
  assign guard_facing = facing_q;
  assign moving       = (state_q == WALK);
  assign blocked      = (state_q == BLOCKED);

endmodule
